serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001: The module SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002: The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003: The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004: The module SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005: The module SHALL have port a, input, WIDTH bits: operand A; captured on the accepting edge.
REQ-006: The module SHALL have port b, input, WIDTH bits: operand B; captured on the accepting edge.
REQ-007: The module SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008: The module SHALL have port done, output, 1 bit: single-cycle pulse; result valid.
REQ-009: The module SHALL have port sum, output, WIDTH bits: result a+b mod 2^WIDTH.
REQ-010: The module SHALL have port cout, output, 1 bit: carry out of the MSB.

Function
REQ-011: The module SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN on rising edge with start=1.
- RUN->DONE after WIDTH RUN edges.
- DONE->IDLE unconditionally on the next edge.
REQ-012: On the accepting edge the module SHALL load a and b into internal shift registers, clear the carry register (see REQ-024), and clear the bit counter to 0.
REQ-013: Each RUN edge SHALL process one bit, LSB first:
- bit sum = a_bit ^ b_bit ^ carry, built as two cascaded half adders;
- new carry = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
- the sum bit shifts into sum from the MSB side; the operand registers shift right; the counter increments.
REQ-014: After WIDTH RUN edges, sum SHALL equal (a+b) mod 2^WIDTH and cout SHALL equal bit WIDTH of a+b.
REQ-015: Latency: done SHALL be high in exactly the cycle following the WIDTH-th RUN edge, i.e. WIDTH clock cycles after the accepting edge, for one cycle only.
REQ-016: busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-017: start SHALL be ignored in RUN and DONE, with no queuing.
- A new operation requires start=1 in IDLE.
- Minimum issue interval is WIDTH+2 cycles.
REQ-018: sum and cout SHALL hold their last result from DONE until the next accepting edge.
- Intermediate partial values are visible during RUN; consumers use done only.
REQ-019: Changes on a and b outside the accepting edge SHALL NOT affect the operation in progress.
REQ-020: The counter SHALL be sized clog2(WIDTH)+1 bits so that the WIDTH-th step does not wrap before the RUN->DONE compare.

Reset
REQ-021: Asserting rst_n=0 SHALL asynchronously force:
- state=IDLE;
- busy=0, done=0, sum=0, cout=0;
- carry, counter and operand registers to 0.
REQ-022: Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept start normally.
REQ-023: After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-024: Macro SERIAL_ADDER_CIN_EN SHALL control the carry-in feature.
- Defined: adds input port cin (1 bit); the accepting edge loads the carry register with cin; result = a+b+cin.
- Undefined: no cin port; the carry register loads 0.
- Timing, latency and reset behaviour SHALL be identical in both builds.

Verification
REQ-025: WIDTH=8: a=8'h0F, b=8'h01, start for 1 cycle -> busy=1 for 8 cycles, then done=1 for 1 cycle with sum=8'h10, cout=0.
REQ-026: WIDTH=8: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1 at done; a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
REQ-027: Start 8'h12+8'h34; pulse start with a=8'hAA, b=8'hAA at RUN cycle 3 -> single done, sum=8'h46, cout=0, no second operation.
REQ-028: Start 8'hF0+8'h0F; assert rst_n=0 at RUN cycle 4 -> immediately busy=0, sum=0, no done; after release, 8'h01+8'h02 -> sum=8'h03.
REQ-029: Back-to-back: start held high continuously -> operations accepted every 10 cycles (WIDTH+2); sum/cout stable between dones.
REQ-030: With SERIAL_ADDER_CIN_EN defined: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1; with cin=0 -> sum=8'hFF, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock.
// Optional carry-in port enabled by `define SERIAL_ADDER_CIN_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic           carry_init;
  logic           h1_s;
  logic           h1_c;
  logic           h2_s;
  logic           h2_c;
  logic           c_nxt;
  logic [CW-1:0]  cnt_nxt;

`ifdef SERIAL_ADDER_CIN_EN
  assign carry_init = cin;
`else
  assign carry_init = 1'b0;
`endif

  // full adder as two cascaded half adders
  assign h1_s    = a_q[0] ^ b_q[0];
  assign h1_c    = a_q[0] & b_q[0];
  assign h2_s    = h1_s ^ carry;
  assign h2_c    = h1_s & carry;
  assign c_nxt   = h1_c | h2_c;
  assign cnt_nxt = cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= carry_init;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= c_nxt;
          sum   <= {h2_s, sum[WIDTH-1:1]};
          cnt   <= cnt_nxt;
          // counter is one bit wider so WIDTH itself is reachable
          if (cnt_nxt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= c_nxt;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
// Carry-in vectors run only when SERIAL_ADDER_CIN_EN is defined.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
`ifdef SERIAL_ADDER_CIN_EN
  logic       cin;
`endif
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADDER_CIN_EN
    .cin   (cin),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // issue one op, scramble operands afterwards, check latency and result
  task automatic do_op(input string tag,
                       input logic [7:0] x,
                       input logic [7:0] y,
                       input logic [7:0] es,
                       input logic ec);
    int n;
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, 8);
    check({tag, "_done"}, done, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_sum_hold"}, sum, es);
  endtask

  initial begin
    int n;
    int nd;
    int last;
    bit pend;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADDER_CIN_EN
    cin = 1'b0;
`endif
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("v0f01", 8'h0F, 8'h01, 8'h10, 1'b0);
    do_op("vff01", 8'hFF, 8'h01, 8'h00, 1'b1);
    do_op("vffff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

    // start during RUN must be ignored
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hAA;
    b = 8'hAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("ign_busy_cycles", n, 8);
    check("ign_done", done, 1);
    check("ign_sum", sum, 8'h46);
    check("ign_cout", cout, 0);
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy || done) n++;
    end
    check("ign_no_second", n, 0);

    // reset in the middle of RUN
    @(negedge clk);
    a = 8'hF0;
    b = 8'h0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_done", done, 0);
    check("abort_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    check("abort_quiet", n, 0);
    do_op("post_rst", 8'h01, 8'h02, 8'h03, 1'b0);

    // start held high: one accept every 10 cycles
    @(negedge clk);
    a = 8'h05;
    b = 8'h03;
    start = 1'b1;
    nd = 0;
    last = -1;
    pend = 1'b0;
    for (int cy = 0; cy < 35; cy++) begin
      @(negedge clk);
      if (pend) begin
        check("b2b_hold", sum, 8'h08);
        pend = 1'b0;
      end
      if (done) begin
        check("b2b_sum", sum, 8'h08);
        if (last >= 0) check("b2b_gap", cy - last, 10);
        last = cy;
        nd++;
        pend = 1'b1;
      end
    end
    check("b2b_count", nd, 3);
    start = 1'b0;
    repeat (12) @(negedge clk);

`ifdef SERIAL_ADDER_CIN_EN
    cin = 1'b1;
    do_op("cin1", 8'hFF, 8'h00, 8'h00, 1'b1);
    cin = 1'b0;
    do_op("cin0", 8'hFF, 8'h00, 8'hFF, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
